// File: rtl/bios_boot_loader.sv
// Copies NUM_WORDS words from a combinational BIOS ROM into instruction memory,
// holding the CPU in halt until the copy has finished.
module bios_boot_loader #(
    parameter int NUM_WORDS = 32,
    parameter int AUTO_BOOT = 1
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        start,
    output logic [4:0]  bios_addr,
    input  logic [16:0] bios_data,
    output logic        imem_wr_en,
    output logic [4:0]  imem_wr_addr,
    output logic [16:0] imem_wr_data,
    input  logic        imem_wr_ready,
    output logic        cpu_halt,
    output logic        busy,
    output logic        done,
    output logic [5:0]  mc_count
);

    localparam logic [4:0] LAST_IDX = 5'(NUM_WORDS - 1);
    localparam bit         AUTO     = (AUTO_BOOT != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_reg,    state_next;
    logic [4:0]  index_reg,    index_next;
    logic [4:0]  wr_addr_reg,  wr_addr_next;
    logic [16:0] wr_data_reg,  wr_data_next;
    logic [5:0]  mc_count_reg, mc_count_next;
    // Goes high one edge after reset release, so the first FETCH lands on the
    // second edge at the earliest.
    logic        armed_reg;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg    <= IDLE;
            index_reg    <= '0;
            wr_addr_reg  <= '0;
            wr_data_reg  <= '0;
            mc_count_reg <= '0;
            armed_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            index_reg    <= index_next;
            wr_addr_reg  <= wr_addr_next;
            wr_data_reg  <= wr_data_next;
            mc_count_reg <= mc_count_next;
            armed_reg    <= 1'b1;
        end
    end

    always_comb begin
        state_next    = state_reg;
        index_next    = index_reg;
        wr_addr_next  = wr_addr_reg;
        wr_data_next  = wr_data_reg;
        mc_count_next = mc_count_reg;
        case (state_reg)
            IDLE: begin
                if (armed_reg && (AUTO || start)) begin
                    state_next    = FETCH;
                    index_next    = '0;
                    mc_count_next = '0;
                end
            end
            FETCH: begin
                wr_addr_next = index_reg;
                wr_data_next = bios_data;
                state_next   = WRITE;
            end
            WRITE: begin
                if (imem_wr_ready) begin
                    if (wr_data_reg[16]) begin
                        mc_count_next = mc_count_reg + 6'd1;
                    end
                    if (index_reg == LAST_IDX) begin
                        state_next = DONE;
                    end else begin
                        index_next = index_reg + 5'd1;
                        state_next = FETCH;
                    end
                end
            end
            DONE: begin
                if (start) begin
                    state_next    = FETCH;
                    index_next    = '0;
                    mc_count_next = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Status outputs decode straight from the state so reset takes them immediately.
    assign bios_addr    = index_reg;
    assign imem_wr_en   = (state_reg == WRITE);
    assign imem_wr_addr = wr_addr_reg;
    assign imem_wr_data = wr_data_reg;
    assign busy         = (state_reg == FETCH) || (state_reg == WRITE);
    assign done         = (state_reg == DONE);
    assign cpu_halt     = (state_reg != DONE);
    assign mc_count     = mc_count_reg;

endmodule

// File: tb/tb_bios_boot_loader.sv
// Randomized self-checking bench: ROM contents and write back-pressure are random,
// expected write streams, counts and load times come from a simple load model.
module tb_bios_boot_loader;

    localparam int NA = 32;
    localparam int NB = 2;

    logic        clk, rst_n, start_a, start_b, ready_a;
    logic [4:0]  baddr_a, waddr_a, baddr_b, waddr_b;
    logic [16:0] bdata_a, wdata_a, bdata_b, wdata_b;
    logic        en_a, halt_a, busy_a, done_a;
    logic        en_b, halt_b, busy_b, done_b;
    logic [5:0]  mc_a, mc_b;

    logic [16:0] rom_a [32];
    logic [16:0] rom_b [32];
    assign bdata_a = rom_a[baddr_a];
    assign bdata_b = rom_b[baddr_b];

    int total, bad;

    // Observation state filled by the monitor
    logic [21:0] got_a [$];
    logic [21:0] got_b [$];
    int          busy_cyc_a, busy_cyc_b, done_rises_a;
    logic        prev_done_a;
    bit          hold_pending;
    logic [4:0]  hold_addr;
    logic [16:0] hold_data;
    int          stall_rem [32];
    int          plan_sum;

    bios_boot_loader #(.NUM_WORDS(NA), .AUTO_BOOT(1)) dut_a (
        .Clock(clk), .Reset_n(rst_n), .start(start_a),
        .bios_addr(baddr_a), .bios_data(bdata_a),
        .imem_wr_en(en_a), .imem_wr_addr(waddr_a), .imem_wr_data(wdata_a),
        .imem_wr_ready(ready_a), .cpu_halt(halt_a), .busy(busy_a),
        .done(done_a), .mc_count(mc_a)
    );

    bios_boot_loader #(.NUM_WORDS(NB), .AUTO_BOOT(0)) dut_b (
        .Clock(clk), .Reset_n(rst_n), .start(start_b),
        .bios_addr(baddr_b), .bios_data(bdata_b),
        .imem_wr_en(en_b), .imem_wr_addr(waddr_b), .imem_wr_data(wdata_b),
        .imem_wr_ready(1'b1), .cpu_halt(halt_b), .busy(busy_b),
        .done(done_b), .mc_count(mc_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Monitor and back-pressure driver: ready is decided on the falling edge for
    // the following rising edge, using a per-address stall plan.
    initial begin
        ready_a = 1'b1;
        forever begin
            @(negedge clk);
            if (hold_pending) begin
                check("hold_en", {31'd0, en_a}, 1);
                check("hold_addr", {27'd0, waddr_a}, {27'd0, hold_addr});
                check("hold_data", {15'd0, wdata_a}, {15'd0, hold_data});
                hold_pending = 1'b0;
            end
            if (en_a) begin
                if (stall_rem[waddr_a] != 0) begin
                    ready_a = 1'b0;
                    stall_rem[waddr_a]--;
                    hold_pending = 1'b1;
                    hold_addr = waddr_a;
                    hold_data = wdata_a;
                end else begin
                    ready_a = 1'b1;
                    got_a.push_back({waddr_a, wdata_a});
                    $display("write a addr=%0d data=%05h", waddr_a, wdata_a);
                end
            end else begin
                ready_a = 1'($urandom_range(0, 1));
            end
            if (busy_a) busy_cyc_a++;
            if (done_a && !prev_done_a) done_rises_a++;
            prev_done_a = done_a;
            if (en_b) begin
                got_b.push_back({waddr_b, wdata_b});
                $display("write b addr=%0d data=%05h", waddr_b, wdata_b);
            end
            if (busy_b) busy_cyc_b++;
        end
    end

    task automatic set_plan(input int mode);
        plan_sum = 0;
        for (int i = 0; i < 32; i++) begin
            stall_rem[i] = 0;
            if (mode == 2 && $urandom_range(0, 3) == 0) stall_rem[i] = $urandom_range(1, 3);
        end
        if (mode == 1) stall_rem[5] = 3;
        for (int i = 0; i < 32; i++) plan_sum += stall_rem[i];
    endtask

    task automatic reset_and_release();
        rst_n = 1'b0;
        #1;
        check("rst_en", {31'd0, en_a}, 0);
        check("rst_halt", {31'd0, halt_a}, 1);
        check("rst_busy", {31'd0, busy_a}, 0);
        check("rst_done", {31'd0, done_a}, 0);
        check("rst_baddr", {27'd0, baddr_a}, 0);
        check("rst_waddr", {27'd0, waddr_a}, 0);
        check("rst_wdata", {15'd0, wdata_a}, 0);
        check("rst_mc", {26'd0, mc_a}, 0);
        got_a.delete();
        busy_cyc_a = 0;
        done_rises_a = 0;
        prev_done_a = 1'b0;
        hold_pending = 1'b0;
        set_plan(0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_edge1_idle", {31'd0, busy_a}, 0);
        @(posedge clk); #1;
        check("rel_edge2_fetch", {31'd0, busy_a}, 1);
    endtask

    task automatic wait_done_a(input int limit, input bit poke);
        int n;
        n = 0;
        while (done_a !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
            if (done_a === 1'b1) start_a = 1'b0;
            else if (poke) start_a = ($urandom_range(0, 15) == 0);
        end
        start_a = 1'b0;
        #1;
        check("a_done_seen", {31'd0, done_a}, 1);
    endtask

    // A load must write every ROM word once, in address order, in 2N+stall cycles.
    task automatic check_load(input string tag, input int exp_time);
        int exp_mc;
        exp_mc = 0;
        check({tag, "_nwrites"}, got_a.size(), NA);
        for (int i = 0; i < NA; i++) begin
            if (rom_a[i][16]) exp_mc++;
            if (i < got_a.size()) begin
                check({tag, "_addr"}, {27'd0, got_a[i][21:17]}, i);
                check({tag, "_data"}, {15'd0, got_a[i][16:0]}, {15'd0, rom_a[i]});
            end
        end
        check({tag, "_mc"}, {26'd0, mc_a}, exp_mc);
        check({tag, "_time"}, busy_cyc_a, exp_time);
        check({tag, "_done_once"}, done_rises_a, 1);
        check({tag, "_halt"}, {31'd0, halt_a}, 0);
        check({tag, "_en_idle"}, {31'd0, en_a}, 0);
    endtask

    initial begin
        bit found;
        total = 0;
        bad = 0;
        start_a = 1'b0;
        start_b = 1'b0;
        rst_n = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rom_a[i] = {i[0], 16'hA000 + 16'(i)};
            rom_b[i] = 17'($urandom);
        end

        // Power-up auto boot, with a start pulse mid-load that must be ignored
        reset_and_release();
        set_plan(0);
        repeat (10) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done_a(400, 1'b0);
        check_load("boot", 2 * NA + plan_sum);

        // Reload from DONE, with three stall cycles on address 5
        got_a.delete();
        busy_cyc_a = 0;
        done_rises_a = 0;
        set_plan(1);
        start_a = 1'b1;
        @(posedge clk); #1;
        check("restart_halt", {31'd0, halt_a}, 1);
        check("restart_busy", {31'd0, busy_a}, 1);
        check("restart_done", {31'd0, done_a}, 0);
        check("restart_baddr", {27'd0, baddr_a}, 0);
        check("restart_mc", {26'd0, mc_a}, 0);
        @(negedge clk);
        start_a = 1'b0;
        wait_done_a(400, 1'b0);
        check_load("reload", 2 * NA + 3);

        // Random ROMs, random back-pressure, random start noise
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 32; i++) rom_a[i] = 17'($urandom);
            reset_and_release();
            set_plan(2);
            wait_done_a(1000, 1'b1);
            check_load("rand", 2 * NA + plan_sum);
        end

        // Reset while writing index 12, then a clean reload
        for (int i = 0; i < 32; i++) rom_a[i] = 17'($urandom);
        reset_and_release();
        set_plan(0);
        found = 1'b0;
        for (int n = 0; n < 200 && !found; n++) begin
            @(negedge clk);
            if (en_a && waddr_a == 5'd12) found = 1'b1;
        end
        check("found_write12", {31'd0, found}, 1);
        reset_and_release();
        set_plan(2);
        wait_done_a(1000, 1'b0);
        check_load("after_reset", 2 * NA + plan_sum);

        // Manual-boot, two-word instance: idle until start, then 4 busy cycles
        check("b_idle_busy_cycles", busy_cyc_b, 0);
        check("b_idle_halt", {31'd0, halt_b}, 1);
        check("b_idle_done", {31'd0, done_b}, 0);
        got_b.delete();
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int n = 0; n < 50 && done_b !== 1'b1; n++) @(negedge clk);
        #1;
        check("b_done_seen", {31'd0, done_b}, 1);
        check("b_time", busy_cyc_b, 2 * NB);
        check("b_nwrites", got_b.size(), NB);
        begin
            int exp_mc;
            exp_mc = 0;
            for (int i = 0; i < NB; i++) begin
                if (rom_b[i][16]) exp_mc++;
                if (i < got_b.size()) begin
                    check("b_addr", {27'd0, got_b[i][21:17]}, i);
                    check("b_data", {15'd0, got_b[i][16:0]}, {15'd0, rom_b[i]});
                end
            end
            check("b_mc", {26'd0, mc_b}, exp_mc);
        end
        check("b_halt_released", {31'd0, halt_b}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
